// File: rtl/edge_frame_buffer_pkg.sv
// Shared types and helpers for the double-buffered edge frame store.
package edge_frame_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FILL      = 2'd1,
        WAIT_SWAP = 2'd2
    } wrState_t;

    // Bits needed to address a linear pixel index of a whole frame.
    function automatic int fbIdxWidth(input int pixels);
        int w;
        w = 1;
        while ((1 << w) < pixels) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/fb_bank_ram.sv
// 1-bit simple dual-port bank: one write port, one registered read port.
// Contents are deliberately not reset; the top gates the output until valid.
module fb_bank_ram #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic              wrData,
    input  logic [ADDR_W-1:0] rdAddr,
    output logic              rdData
);

    logic mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        rdData <= mem[rdAddr];
    end

endmodule

// File: rtl/edge_frame_buffer.sv
// Double-buffered 1-bit frame store between the edge detector stream and
// the VGA output stage. One bank is displayed while the other fills; the
// banks swap at the first display frame boundary after a complete frame.
//
// state     | meaning
// IDLE      | waiting for a start-of-frame beat, other beats dropped
// FILL      | writing beats into the back bank in raster order
// WAIT_SWAP | back bank complete, stalled until frame_sync swaps banks
module edge_frame_buffer
    import edge_frame_buffer_pkg::*;
#(
    parameter int WIDTH      = 160,
    parameter int HEIGHT     = 120,
    parameter int SCALE_LOG2 = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic       s_pixel,
    input  logic       s_sof,
    input  logic       frame_sync,
    input  logic [9:0] rd_x,
    input  logic [9:0] rd_y,
    output logic       rd_pixel,
    output logic [7:0] frame_count,
    output logic       frame_err
);

    localparam int PIX   = WIDTH * HEIGHT;
    localparam int IDX_W = fbIdxWidth(PIX);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIX - 1);

    wrState_t          state;
    wrState_t          stateNext;
    logic [IDX_W-1:0]  wrIdx;
    logic [IDX_W-1:0]  wrAddr;
    logic              lastBeat;
    logic              wrEn;
    logic              swapNow;
    logic              dispBank;
    logic              dispValid;

    logic [9:0]        ix;
    logic [9:0]        iy;
    logic              inRange;
    logic [IDX_W-1:0]  rdAddr;
    logic              rdGate;
    logic              rdBankSel;
    logic              bank0Q;
    logic              bank1Q;

    // A start-of-frame beat always restarts the frame at index 0.
    assign wrAddr   = s_sof ? '0 : wrIdx;
    assign lastBeat = (wrAddr == LAST_IDX);

    // Write FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next state, handshake decode and write/swap strobes.
    always_comb begin
        stateNext = state;
        s_ready   = 1'b0;
        wrEn      = 1'b0;
        swapNow   = 1'b0;
        case (state)
            IDLE: begin
                s_ready = 1'b1;
                if (s_valid && s_sof) begin
                    wrEn      = 1'b1;
                    stateNext = lastBeat ? WAIT_SWAP : FILL;
                end
            end
            FILL: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    wrEn = 1'b1;
                    if (lastBeat) begin
                        stateNext = WAIT_SWAP;
                    end
                end
            end
            WAIT_SWAP: begin
                if (frame_sync) begin
                    swapNow   = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Write index, bank ownership, frame counter and sticky error.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrIdx       <= '0;
            dispBank    <= 1'b0;
            dispValid   <= 1'b0;
            frame_count <= 8'd0;
            frame_err   <= 1'b0;
        end else begin
            if (wrEn) begin
                wrIdx <= lastBeat ? '0 : wrAddr + IDX_W'(1);
            end
            if (wrEn && (state == FILL) && s_sof) begin
                frame_err <= 1'b1;
            end
            if (swapNow) begin
                dispBank    <= ~dispBank;
                dispValid   <= 1'b1;
                frame_count <= frame_count + 8'd1;
            end
        end
    end

    // Screen coordinates to stored-image index; out-of-image reads use
    // address 0 and are blanked by rdGate.
    assign ix      = rd_x >> SCALE_LOG2;
    assign iy      = rd_y >> SCALE_LOG2;
    assign inRange = (ix < 10'(WIDTH)) && (iy < 10'(HEIGHT));
    assign rdAddr  = inRange ? (IDX_W'(iy) * IDX_W'(WIDTH) + IDX_W'(ix)) : '0;

    // Blanking and bank select, aligned with the RAM read register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdGate    <= 1'b0;
            rdBankSel <= 1'b0;
        end else begin
            rdGate    <= dispValid && inRange;
            rdBankSel <= dispBank;
        end
    end

    // The back bank is always the one not being displayed.
    fb_bank_ram #(
        .DEPTH  (PIX),
        .ADDR_W (IDX_W)
    ) u_bank0 (
        .clk    (clk),
        .wrEn   (wrEn && dispBank),
        .wrAddr (wrAddr),
        .wrData (s_pixel),
        .rdAddr (rdAddr),
        .rdData (bank0Q)
    );

    fb_bank_ram #(
        .DEPTH  (PIX),
        .ADDR_W (IDX_W)
    ) u_bank1 (
        .clk    (clk),
        .wrEn   (wrEn && !dispBank),
        .wrAddr (wrAddr),
        .wrData (s_pixel),
        .rdAddr (rdAddr),
        .rdData (bank1Q)
    );

    assign rd_pixel = rdGate & (rdBankSel ? bank1Q : bank0Q);

endmodule

// File: tb/tb_edge_frame_buffer.sv
// Self-checking bench for edge_frame_buffer on a 4x2 image, unscaled.
module tb_edge_frame_buffer;

    localparam int W = 4;
    localparam int H = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic       s_pixel = 1'b0;
    logic       s_sof = 1'b0;
    logic       frame_sync = 1'b0;
    logic [9:0] rd_x = 10'd0;
    logic [9:0] rd_y = 10'd0;
    logic       rd_pixel;
    logic [7:0] frame_count;
    logic       frame_err;

    int nTests = 0;
    int nFail  = 0;

    logic       expQ[$];
    logic [0:7] shown;
    bit         shownValid = 1'b0;

    edge_frame_buffer #(
        .WIDTH      (W),
        .HEIGHT     (H),
        .SCALE_LOG2 (0)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_pixel     (s_pixel),
        .s_sof       (s_sof),
        .frame_sync  (frame_sync),
        .rd_x        (rd_x),
        .rd_y        (rd_y),
        .rd_pixel    (rd_pixel),
        .frame_count (frame_count),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic modelPixel(input int x, input int y);
        if (!shownValid || x >= W || y >= H) return 1'b0;
        return shown[y * W + x];
    endfunction

    // Stimulus only: one beat on the next rising edge, entered/left at negedge.
    task automatic sendBeat(input logic pix, input logic sof, input logic sync);
        s_valid    = 1'b1;
        s_pixel    = pix;
        s_sof      = sof;
        frame_sync = sync;
        @(posedge clk);
        @(negedge clk);
        s_valid    = 1'b0;
        s_pixel    = 1'b0;
        s_sof      = 1'b0;
        frame_sync = 1'b0;
    endtask

    task automatic pulseSync();
        frame_sync = 1'b1;
        @(posedge clk);
        @(negedge clk);
        frame_sync = 1'b0;
    endtask

    task automatic sendFrame(input logic [0:7] pat);
        for (int i = 0; i < 8; i++) sendBeat(pat[i], (i == 0), 1'b0);
    endtask

    task automatic test_reset();
        logic e;
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        nTests++;
        if (s_ready !== 1'b1) begin nFail++; $display("FAIL reset_s_ready got=%b want=1", s_ready); end
        nTests++;
        if (frame_count !== 8'd0) begin nFail++; $display("FAIL reset_frame_count got=%0d want=0", frame_count); end
        nTests++;
        if (frame_err !== 1'b0) begin nFail++; $display("FAIL reset_frame_err got=%b want=0", frame_err); end
        for (int i = 0; i <= 3; i++) begin
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                nTests++;
                if (rd_pixel !== e) begin nFail++; $display("FAIL reset_read cycle=%0d got=%b want=%b", i, rd_pixel, e); end
            end
            if (i < 3) begin rd_x = 10'd0; rd_y = 10'd0; expQ.push_back(modelPixel(0, 0)); end
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic test_frame();
        logic e;
        int   oxs[3];
        int   oys[3];
        sendFrame(8'b10110010);
        nTests++;
        if (s_ready !== 1'b0) begin nFail++; $display("FAIL frame_ready_after_last got=%b want=0", s_ready); end
        repeat (3) @(negedge clk);
        nTests++;
        if (s_ready !== 1'b0) begin nFail++; $display("FAIL frame_ready_wait got=%b want=0", s_ready); end
        nTests++;
        if (frame_count !== 8'd0) begin nFail++; $display("FAIL frame_count_before_sync got=%0d want=0", frame_count); end
        pulseSync();
        shown = 8'b10110010;
        shownValid = 1'b1;
        nTests++;
        if (s_ready !== 1'b1) begin nFail++; $display("FAIL frame_ready_after_sync got=%b want=1", s_ready); end
        nTests++;
        if (frame_count !== 8'd1) begin nFail++; $display("FAIL frame_count_after_sync got=%0d want=1", frame_count); end
        for (int i = 0; i <= 8; i++) begin
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                nTests++;
                if (rd_pixel !== e) begin nFail++; $display("FAIL frame_read idx=%0d got=%b want=%b", i - 1, rd_pixel, e); end
            end
            if (i < 8) begin rd_x = 10'(i % W); rd_y = 10'(i / W); expQ.push_back(modelPixel(i % W, i / W)); end
            @(posedge clk); @(negedge clk);
        end
        oxs = '{5, 0, 4};
        oys = '{0, 3, 1};
        for (int i = 0; i <= 3; i++) begin
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                nTests++;
                if (rd_pixel !== e) begin nFail++; $display("FAIL out_of_range_read n=%0d got=%b want=%b", i - 1, rd_pixel, e); end
            end
            if (i < 3) begin rd_x = 10'(oxs[i]); rd_y = 10'(oys[i]); expQ.push_back(modelPixel(oxs[i], oys[i])); end
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic test_discard();
        logic e;
        for (int i = 0; i < 3; i++) sendBeat(1'b1, 1'b0, 1'b0);
        nTests++;
        if (s_ready !== 1'b1) begin nFail++; $display("FAIL discard_ready got=%b want=1", s_ready); end
        sendFrame(8'b01001101);
        pulseSync();
        shown = 8'b01001101;
        nTests++;
        if (frame_count !== 8'd2) begin nFail++; $display("FAIL discard_frame_count got=%0d want=2", frame_count); end
        nTests++;
        if (frame_err !== 1'b0) begin nFail++; $display("FAIL discard_frame_err got=%b want=0", frame_err); end
        for (int i = 0; i <= 8; i++) begin
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                nTests++;
                if (rd_pixel !== e) begin nFail++; $display("FAIL discard_read idx=%0d got=%b want=%b", i - 1, rd_pixel, e); end
            end
            if (i < 8) begin rd_x = 10'(i % W); rd_y = 10'(i / W); expQ.push_back(modelPixel(i % W, i / W)); end
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic test_error();
        logic e;
        for (int i = 0; i < 3; i++) sendBeat(1'b0, (i == 0), 1'b0);
        nTests++;
        if (frame_err !== 1'b0) begin nFail++; $display("FAIL error_before_resync got=%b want=0", frame_err); end
        sendFrame(8'b11111111);
        nTests++;
        if (frame_err !== 1'b1) begin nFail++; $display("FAIL error_sticky got=%b want=1", frame_err); end
        nTests++;
        if (s_ready !== 1'b0) begin nFail++; $display("FAIL error_ready_wait got=%b want=0", s_ready); end
        pulseSync();
        shown = 8'b11111111;
        nTests++;
        if (frame_count !== 8'd3) begin nFail++; $display("FAIL error_frame_count got=%0d want=3", frame_count); end
        for (int i = 0; i <= 8; i++) begin
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                nTests++;
                if (rd_pixel !== e) begin nFail++; $display("FAIL error_read idx=%0d got=%b want=%b", i - 1, rd_pixel, e); end
            end
            if (i < 8) begin rd_x = 10'(i % W); rd_y = 10'(i / W); expQ.push_back(modelPixel(i % W, i / W)); end
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic test_sync_collision();
        logic       e;
        logic [0:7] pat;
        pat = 8'b00011000;
        for (int i = 0; i < 8; i++) sendBeat(pat[i], (i == 0), (i == 7));
        nTests++;
        if (s_ready !== 1'b0) begin nFail++; $display("FAIL collision_ready got=%b want=0", s_ready); end
        nTests++;
        if (frame_count !== 8'd3) begin nFail++; $display("FAIL collision_no_swap_count got=%0d want=3", frame_count); end
        for (int i = 0; i <= 8; i++) begin
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                nTests++;
                if (rd_pixel !== e) begin nFail++; $display("FAIL collision_old_read idx=%0d got=%b want=%b", i - 1, rd_pixel, e); end
            end
            if (i < 8) begin rd_x = 10'(i % W); rd_y = 10'(i / W); expQ.push_back(modelPixel(i % W, i / W)); end
            @(posedge clk); @(negedge clk);
        end
        pulseSync();
        shown = pat;
        nTests++;
        if (frame_count !== 8'd4) begin nFail++; $display("FAIL collision_swap_count got=%0d want=4", frame_count); end
        for (int i = 0; i <= 8; i++) begin
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                nTests++;
                if (rd_pixel !== e) begin nFail++; $display("FAIL collision_new_read idx=%0d got=%b want=%b", i - 1, rd_pixel, e); end
            end
            if (i < 8) begin rd_x = 10'(i % W); rd_y = 10'(i / W); expQ.push_back(modelPixel(i % W, i / W)); end
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        logic e;
        sendBeat(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) sendBeat(1'b1, 1'b0, 1'b0);
        rd_x = 10'd3;
        rd_y = 10'd0;
        @(posedge clk); @(negedge clk);
        nTests++;
        if (rd_pixel !== modelPixel(3, 0)) begin nFail++; $display("FAIL reset_mid_pre_read got=%b want=%b", rd_pixel, modelPixel(3, 0)); end
        reset_n = 1'b0;
        shownValid = 1'b0;
        @(posedge clk); @(negedge clk);
        nTests++;
        if (rd_pixel !== 1'b0) begin nFail++; $display("FAIL reset_mid_rd_pixel got=%b want=0", rd_pixel); end
        nTests++;
        if (frame_count !== 8'd0) begin nFail++; $display("FAIL reset_mid_frame_count got=%0d want=0", frame_count); end
        nTests++;
        if (frame_err !== 1'b0) begin nFail++; $display("FAIL reset_mid_frame_err got=%b want=0", frame_err); end
        reset_n = 1'b1;
        @(posedge clk); @(negedge clk);
        nTests++;
        if (rd_pixel !== 1'b0) begin nFail++; $display("FAIL reset_mid_blank got=%b want=0", rd_pixel); end
        nTests++;
        if (s_ready !== 1'b1) begin nFail++; $display("FAIL reset_mid_ready got=%b want=1", s_ready); end
        sendFrame(8'b11100001);
        pulseSync();
        shown = 8'b11100001;
        shownValid = 1'b1;
        nTests++;
        if (frame_count !== 8'd1) begin nFail++; $display("FAIL reset_mid_recount got=%0d want=1", frame_count); end
        for (int i = 0; i <= 8; i++) begin
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                nTests++;
                if (rd_pixel !== e) begin nFail++; $display("FAIL reset_mid_read idx=%0d got=%b want=%b", i - 1, rd_pixel, e); end
            end
            if (i < 8) begin rd_x = 10'(i % W); rd_y = 10'(i / W); expQ.push_back(modelPixel(i % W, i / W)); end
            @(posedge clk); @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_discard();
        test_error();
        test_sync_collision();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
